// File: rtl/display_7seg_mux_if.sv
// Load-side bundle of the multiplexed 7-segment driver: the datapath drives the
// new display word, its blanking controls and the load strobe.
interface display_7seg_mux_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     blank_mask;
  logic                    lz_blank;

  modport master (output load, value, blank_mask, lz_blank);
  modport slave  (input  load, value, blank_mask, lz_blank);
endinterface

// File: rtl/display_7seg_mux.sv
// Time-multiplexed N-digit hex 7-segment driver with frame-synchronous update,
// leading-zero / per-digit blanking and an all-off guard cycle per digit slot.
module display_7seg_mux #(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_7seg_mux_if.slave    bus,
  output logic [6:0]           seg,
  output logic [N_DIGITS-1:0]  an,
  output logic                 frame_tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * N_DIGITS;
  localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : '0;

  // Lit-segment pattern, bit 0 = a .. bit 6 = g
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [VAL_W-1:0]    shadow_val_q, shadow_val_d;
  logic [N_DIGITS-1:0] shadow_mask_q, shadow_mask_d;
  logic [VAL_W-1:0]    disp_val_q, disp_val_d;
  logic [N_DIGITS-1:0] disp_mask_q, disp_mask_d;
  logic                pending_q, pending_d;
  logic                tick_q, tick_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic                slot_end_c, frame_end_c;
  logic [3:0]          nib_c;
  logic                mask_c, upper_zero_c, dark_c;
  logic [6:0]          lit_c;
  logic [N_DIGITS-1:0] sel_c;

  // Scan position, tear-free load commit and next output word
  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shadow_val_d  = shadow_val_q;
    shadow_mask_d = shadow_mask_q;
    disp_val_d    = disp_val_q;
    disp_mask_d   = disp_mask_q;
    pending_d     = pending_q;
    tick_d        = 1'b0;
    seg_d         = SEG_OFF;
    an_d          = AN_OFF;
    nib_c         = 4'h0;
    mask_c        = 1'b0;
    upper_zero_c  = 1'b1;
    sel_c         = '0;

    slot_end_c  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_end_c = slot_end_c && (idx_q == IDX_W'(N_DIGITS - 1));

    if (slot_end_c) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (bus.load) begin
      shadow_val_d  = bus.value;
      shadow_mask_d = bus.blank_mask;
      pending_d     = 1'b1;
    end
    // A load on the boundary cycle is already in shadow_*_d, so it bypasses
    if (frame_end_c && pending_d) begin
      disp_val_d  = shadow_val_d;
      disp_mask_d = shadow_mask_d;
      pending_d   = 1'b0;
      tick_d      = 1'b1;
    end

    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (IDX_W'(j) == idx_q) begin
        nib_c    = disp_val_q[4*j +: 4];
        mask_c   = disp_mask_q[j];
        sel_c[j] = 1'b1;
      end
      if ((IDX_W'(j) >= idx_q) && (disp_val_q[4*j +: 4] != 4'h0)) begin
        upper_zero_c = 1'b0;
      end
    end

    dark_c = mask_c || (bus.lz_blank && upper_zero_c && (idx_q != '0));
    lit_c  = dark_c ? 7'h00 : glyph(nib_c);

    if (cnt_q != '0) begin
      seg_d = SEG_ACTIVE_LOW ? ~lit_c : lit_c;
      an_d  = AN_ACTIVE_LOW ? ~sel_c : sel_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_val_q  <= '0;
      shadow_mask_q <= '0;
      disp_val_q    <= '0;
      disp_mask_q   <= '0;
      pending_q     <= 1'b0;
      tick_q        <= 1'b0;
      seg_q         <= SEG_OFF;
      an_q          <= AN_OFF;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_val_q  <= shadow_val_d;
      shadow_mask_q <= shadow_mask_d;
      disp_val_q    <= disp_val_d;
      disp_mask_q   <= disp_mask_d;
      pending_q     <= pending_d;
      tick_q        <= tick_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/display_7seg_mux.md
Name: display_7seg_mux

Overview:
- Time-multiplexed N-digit hexadecimal 7-segment display driver; successor to the single-digit combinational hex decoder.
- Accepts a packed word of 4-bit nibbles and scans one digit at a time onto a shared segment bus with one enable per digit.
- Adds tear-free frame-synchronous updates, leading-zero blanking, per-digit blanking and an anti-ghosting guard cycle.
- Sits between datapath result registers (ULA result and flags) and the board's multiplexed display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned; range 1..8.
- REFRESH_DIV, 50000, clock cycles per digit slot; minimum 2.
- SEG_ACTIVE_LOW, 1, 1: lit segment = 0; 0: lit segment = 1.
- AN_ACTIVE_LOW, 1, 1: selected digit enable = 0; 0: selected = 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  one-cycle strobe; captures value and blank_mask.
- value  input  4*N_DIGITS  nibble k (bits 4k+3:4k) is digit k; digit 0 is least significant.
- blank_mask  input  N_DIGITS  bit k = 1 forces digit k dark.
- lz_blank  input  1  1 = suppress leading zeros (sampled live).
- seg  output  7  segments, seg[0]=a .. seg[6]=g; registered.
- an  output  N_DIGITS  digit enables, at most one active; registered.
- frame_tick  output  1  one-cycle pulse when a pending load is committed to the display.

Behaviour:
- Reset (async, rst_n=0): all segments off (7'h7F when SEG_ACTIVE_LOW); all digits off; prescaler=0; digit index=0; shadow and display registers=0; pending=0; frame_tick=0.
- Release: first digit slot starts on the first clk edge after rst_n deasserts.
- Prescaler cnt counts 0..REFRESH_DIV-1. At cnt==REFRESH_DIV-1: cnt wraps to 0 and idx advances; idx wraps from N_DIGITS-1 to 0.
- Frame boundary = cycle with cnt==REFRESH_DIV-1 and idx==N_DIGITS-1.
- Load path:
  - load=1 writes value and blank_mask into the shadow registers and sets pending.
  - At a frame boundary with pending=1: display <= shadow, pending <= 0, frame_tick=1 on the next cycle.
  - Multiple loads within one frame: last load wins.
- Simultaneous load and frame boundary: the incoming value and blank_mask are committed directly to display (bypass). pending ends at 0, and frame_tick pulses.
- Guard cycle: in a slot's cycle with cnt==0, seg and an are registered all-off. For cnt 1..REFRESH_DIV-1, an selects digit idx and seg shows its glyph.
- Output latency: one register stage from (cnt, idx, display).
- Digit k is dark when any of these holds:
  - blank_mask bit k = 1;
  - lz_blank=1, nibble k = 0, all nibbles above k are 0, and k != 0.
  Digit 0 is never LZ-blanked. A dark digit keeps its an active, with seg all off.
- Glyphs (lit segments): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
- Polarity: segments are inverted when SEG_ACTIVE_LOW=1; enables are inverted when AN_ACTIVE_LOW=1.
- Reset mid-frame: immediate all-off. Shadow, display and pending are discarded; the scan restarts at digit 0, cnt 0.
- Width rules: cnt width = clog2(REFRESH_DIV); idx width = clog2(N_DIGITS), minimum 1. N_DIGITS=1 keeps an permanently selected outside guard cycles.

Test Plan:
(all with N_DIGITS=4, REFRESH_DIV=4, both polarities active-low)
- Reset then idle one frame (16 cycles): every guard cycle gives seg=7'h7F, an=4'hF; digit 0 active cycles give an=4'hE, seg=7'h40 ("0"). Digits 1-3 show "0" with lz_blank=0.
- Load value=16'h1A3F mid-frame: digits keep the old content until the frame boundary; frame_tick pulses once. In the next frame, digit 3 gives seg=7'h79 ("1"), digit 2 gives 7'h08 ("A"), digit 1 gives 7'h30 ("3"), digit 0 gives 7'h0E ("F").
- lz_blank=1, load 16'h0070: digits 3 and 2 give seg=7'h7F with an active; digit 1 gives 7'h78 ("7"); digit 0 gives 7'h40. Load 16'h0000: only digit 0 is lit, showing "0".
- Load 16'h1111 then 16'h2222 in the same frame: only "2" (7'h24) is displayed; exactly one frame_tick. Load asserted on the boundary cycle commits that value, with no one-frame delay.
- blank_mask=4'b0101 with value=16'h8888: digits 0 and 2 are dark; digits 1 and 3 give 7'h00.
- Assert rst_n=0 at cnt=2 of digit 2: seg and an go off asynchronously. After release, the scan starts at digit 0 showing "0"; pending is cleared, so there is no frame_tick.
